// File: rtl/apb_multi_master.sv
// rtl/apb_multi_master.sv - APB master bridge with multi-slave decode, wait-state timeout and response channel
module apb_multi_master #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 8,
    parameter int NUM_SLAVES = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [ADDR_W-1:0]            cmd_addr,
    input  logic [DATA_W-1:0]            cmd_wdata,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic [NUM_SLAVES-1:0]        PSEL,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [ADDR_W-1:0]            PADDR,
    output logic [DATA_W-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);
    // Slave index width is derived from the slave count and is not a user parameter
    localparam int SEL_W = $clog2(NUM_SLAVES);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [SEL_W:0]   IDX_LIMIT = (SEL_W+1)'(NUM_SLAVES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DECERR = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [NUM_SLAVES-1:0] r_psel, w_psel_nxt;
    logic                  r_penable, w_penable_nxt;
    logic                  r_pwrite, w_pwrite_nxt;
    logic [ADDR_W-1:0]     r_paddr, w_paddr_nxt;
    logic [DATA_W-1:0]     r_pwdata, w_pwdata_nxt;
    logic [CNT_W-1:0]      r_wait_cnt, w_wait_cnt_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    logic                  r_rsp_err, w_rsp_err_nxt;
    logic [DATA_W-1:0]     r_rsp_rdata, w_rsp_rdata_nxt;

    logic [SEL_W-1:0]      w_cmd_idx;
    logic                  w_cmd_decerr;
    logic [NUM_SLAVES-1:0] w_cmd_onehot;
    logic                  w_sel_ready;
    logic                  w_sel_slverr;
    logic [DATA_W-1:0]     w_sel_rdata;
    logic                  w_timeout;

    assign w_cmd_idx    = cmd_addr[ADDR_W-1 -: SEL_W];
    // Indices past the last slave exist when NUM_SLAVES is not a power of two
    assign w_cmd_decerr = ({1'b0, w_cmd_idx} >= IDX_LIMIT);

    // Decode the command's one-hot select and gather the addressed slave's read data
    always_comb begin
        w_cmd_onehot = '0;
        w_sel_rdata  = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (w_cmd_idx == SEL_W'(k)) begin
                w_cmd_onehot[k] = 1'b1;
            end
            if (r_psel[k]) begin
                w_sel_rdata = w_sel_rdata | PRDATA[k*DATA_W +: DATA_W];
            end
        end
    end

    // r_psel is one-hot during a transfer, so masking ignores every other slave
    assign w_sel_ready  = |(PREADY & r_psel);
    assign w_sel_slverr = |(PSLVERR & r_psel);
    assign w_timeout    = (TIMEOUT > 0) && (r_wait_cnt == CNT_LIMIT);

    // Next-state and next-register values for the APB phase sequencer
    always_comb begin
        w_state_nxt     = r_state;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_pwrite_nxt = cmd_write;
                    w_paddr_nxt  = cmd_addr;
                    w_pwdata_nxt = cmd_wdata;
                    if (w_cmd_decerr) begin
                        w_state_nxt = S_DECERR;
                    end else begin
                        w_state_nxt = S_SETUP;
                        w_psel_nxt  = w_cmd_onehot;
                    end
                end
            end
            S_SETUP: begin
                w_state_nxt    = S_ACCESS;
                w_penable_nxt  = 1'b1;
                w_wait_cnt_nxt = '0;
            end
            S_ACCESS: begin
                if (w_sel_ready) begin
                    // Ready on the timeout cycle still counts as a normal completion
                    w_state_nxt     = S_IDLE;
                    w_psel_nxt      = '0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = w_sel_slverr;
                    w_rsp_rdata_nxt = (!r_pwrite && !w_sel_slverr) ? w_sel_rdata : '0;
                end else if (w_timeout) begin
                    w_state_nxt     = S_IDLE;
                    w_psel_nxt      = '0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                end
            end
            S_DECERR: begin
                w_state_nxt     = S_IDLE;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_err_nxt   = 1'b1;
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_psel_nxt    = '0;
                w_penable_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight without a response
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= S_IDLE;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_wait_cnt  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

    assign cmd_ready = (r_state == S_IDLE) && !PRESET;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_multi_master.sv
// tb/tb_apb_multi_master.sv - directed scoreboard bench for apb_multi_master
module tb_apb_multi_master;
    localparam int AW  = 9;
    localparam int DW  = 8;
    localparam int NS  = 2;
    localparam int AW2 = 10;
    localparam int NS2 = 3;

    logic PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    logic            PRESET;
    logic            cmd_write;
    logic [AW2-1:0]  cmd_addr;
    logic [DW-1:0]   cmd_wdata;

    logic            a_cmd_valid, a_cmd_ready, a_rsp_valid, a_rsp_err;
    logic [DW-1:0]   a_rsp_rdata, a_pwdata;
    logic [NS-1:0]   a_psel, a_pready, a_pslverr;
    logic            a_penable, a_pwrite;
    logic [AW-1:0]   a_paddr;
    logic [NS*DW-1:0] a_prdata;

    logic            b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_err;
    logic [DW-1:0]   b_rsp_rdata, b_pwdata;
    logic [NS2-1:0]  b_psel, b_pready, b_pslverr;
    logic            b_penable, b_pwrite;
    logic [AW2-1:0]  b_paddr;
    logic [NS2*DW-1:0] b_prdata;

    apb_multi_master #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS), .TIMEOUT(16)) u_dut_a (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr[AW-1:0]), .cmd_wdata(cmd_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .PSEL(a_psel), .PENABLE(a_penable), .PWRITE(a_pwrite), .PADDR(a_paddr), .PWDATA(a_pwdata),
        .PRDATA(a_prdata), .PREADY(a_pready), .PSLVERR(a_pslverr)
    );

    apb_multi_master #(.ADDR_W(AW2), .DATA_W(DW), .NUM_SLAVES(NS2), .TIMEOUT(16)) u_dut_b (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .PSEL(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite), .PADDR(b_paddr), .PWDATA(b_pwdata),
        .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr)
    );

    // Slave model for DUT A: slave k stays not-ready for wait_n[k] ACCESS cycles, or forever if stuck
    int         acc_cnt = 0;
    int         wait_n [NS];
    logic [NS-1:0] stuck;
    always @(posedge PCLK) begin
        if (a_penable && !(|(a_pready & a_psel))) acc_cnt <= acc_cnt + 1;
        else                                      acc_cnt <= 0;
    end
    always_comb begin
        a_pready = '0;
        for (int k = 0; k < NS; k++) a_pready[k] = !stuck[k] && (acc_cnt >= wait_n[k]);
    end

    // Observation mux so one task can drive either DUT
    logic            dut_b;
    logic            m_ready, m_rsp_valid, m_rsp_err, m_penable;
    logic [DW-1:0]   m_rdata;
    logic [NS2-1:0]  m_psel;
    always_comb begin
        m_ready     = dut_b ? b_cmd_ready : a_cmd_ready;
        m_rsp_valid = dut_b ? b_rsp_valid : a_rsp_valid;
        m_rsp_err   = dut_b ? b_rsp_err   : a_rsp_err;
        m_rdata     = dut_b ? b_rsp_rdata : a_rsp_rdata;
        m_penable   = dut_b ? b_penable   : a_penable;
        m_psel      = dut_b ? b_psel      : {1'b0, a_psel};
    end

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
        int            lat;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    logic [NS2-1:0] psel_c1, psel_ever;
    logic pen_c1, pen_c2, rdy_c1, psel_changed;
    int rsp_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, then compare the response against the scoreboard entry pushed here
    task automatic do_cmd(input string tag, input logic b, input logic wr, input logic [AW2-1:0] addr,
                          input logic [DW-1:0] wd, input logic e_err, input logic [DW-1:0] e_rd, input int e_lat);
        exp_t e;
        int n, lat;
        logic [NS2-1:0] acc;
        e.err = e_err; e.rdata = e_rd; e.lat = e_lat;
        sb.push_back(e);
        dut_b = b; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        if (b) b_cmd_valid = 1'b1; else a_cmd_valid = 1'b1;
        #1;
        n = 0;
        while (m_ready !== 1'b1 && n < 50) begin @(posedge PCLK); #1; n++; end
        chk({tag, "_accept"}, m_ready, 1);
        @(posedge PCLK); #1;
        a_cmd_valid = 1'b0; b_cmd_valid = 1'b0;
        psel_c1 = m_psel; pen_c1 = m_penable; rdy_c1 = m_ready;
        acc = m_psel; psel_changed = 1'b0; pen_c2 = 1'b0;
        lat = 1;
        while (m_rsp_valid !== 1'b1 && lat < 60) begin
            @(posedge PCLK); #1; lat++;
            if (lat == 2) pen_c2 = m_penable;
            if (m_penable && m_psel !== psel_c1) psel_changed = 1'b1;
            acc = acc | m_psel;
        end
        psel_ever = acc;
        e = sb.pop_front();
        chk({tag, "_valid"}, m_rsp_valid, 1);
        chk({tag, "_err"}, m_rsp_err, e.err);
        chk({tag, "_rdata"}, m_rdata, e.rdata);
        chk({tag, "_lat"}, lat, e.lat);
        chk({tag, "_ready_idle"}, m_ready, 1);
        @(posedge PCLK); #1;
        chk({tag, "_pulse"}, m_rsp_valid, 0);
    endtask

    initial begin
        int n;
        PRESET = 1'b1; dut_b = 1'b0;
        a_cmd_valid = 1'b0; b_cmd_valid = 1'b0;
        cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        wait_n[0] = 0; wait_n[1] = 0; stuck = '0;
        a_pslverr = '0; a_prdata = '0;
        b_pready = '1; b_pslverr = '0; b_prdata = 24'h33_22_11;

        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_psel", a_psel, 0);
        chk("rst_penable", a_penable, 0);
        chk("rst_rsp_valid", a_rsp_valid, 0);
        chk("rst_cmd_ready", a_cmd_ready, 0);
        chk("rst_paddr", a_paddr, 0);
        chk("rst_pwdata", a_pwdata, 0);
        chk("rst_b_psel", b_psel, 0);
        PRESET = 1'b0;
        #1;
        chk("rst_release_ready", a_cmd_ready, 1);

        // Write 0x5A to slave 0, zero wait
        a_prdata = 16'h00_99;
        do_cmd("wr_s0", 1'b0, 1'b1, 10'h005, 8'h5A, 1'b0, 8'h00, 3);
        chk("wr_s0_setup_psel", psel_c1, 3'b001);
        chk("wr_s0_setup_penable", pen_c1, 0);
        chk("wr_s0_access_penable", pen_c2, 1);
        chk("wr_s0_ready_busy", rdy_c1, 0);
        chk("wr_s0_psel_stable", psel_changed, 0);
        chk("wr_s0_paddr_hold", a_paddr, 9'h005);
        chk("wr_s0_pwdata_hold", a_pwdata, 8'h5A);
        chk("wr_s0_pwrite_hold", a_pwrite, 1);

        // Read slave 1 with three wait states; slave 0 lines are noise that must be ignored
        wait_n[1] = 3; a_pslverr = 2'b01; a_prdata = 16'hC3_11;
        do_cmd("rd_s1_wait", 1'b0, 1'b0, 10'h105, 8'h00, 1'b0, 8'hC3, 6);
        chk("rd_s1_setup_psel", psel_c1, 3'b010);
        chk("rd_s1_psel_stable", psel_changed, 0);

        // Slave error on read forces rdata to zero
        wait_n[1] = 0; a_pslverr = 2'b10; a_prdata = 16'h77_00;
        do_cmd("rd_s1_slverr", 1'b0, 1'b0, 10'h1F0, 8'h00, 1'b1, 8'h00, 3);
        a_pslverr = '0;

        // Stuck slave: forced completion after 16 ACCESS cycles
        stuck[0] = 1'b1; a_prdata = 16'h00_44;
        do_cmd("rd_s0_timeout", 1'b0, 1'b0, 10'h010, 8'h00, 1'b1, 8'h00, 18);
        stuck[0] = 1'b0;

        // Ready arrives on the limit cycle: normal completion wins
        wait_n[1] = 15; a_prdata = 16'h3C_00;
        do_cmd("rd_s1_ready_at_limit", 1'b0, 1'b0, 10'h1AA, 8'h00, 1'b0, 8'h3C, 18);
        // One cycle later than the limit: timeout
        wait_n[1] = 16;
        do_cmd("rd_s1_ready_after_limit", 1'b0, 1'b0, 10'h1AB, 8'h00, 1'b1, 8'h00, 18);
        wait_n[1] = 0;

        // Reset asserted during ACCESS aborts without a response
        stuck[1] = 1'b1; dut_b = 1'b0; cmd_write = 1'b0; cmd_addr = 10'h101; a_cmd_valid = 1'b1;
        #1;
        n = 0;
        while (a_cmd_ready !== 1'b1 && n < 20) begin @(posedge PCLK); #1; n++; end
        @(posedge PCLK); #1;
        a_cmd_valid = 1'b0;
        @(posedge PCLK); #1;
        chk("abort_in_access", a_penable, 1);
        PRESET = 1'b1;
        #1;
        chk("abort_ready_in_reset", a_cmd_ready, 0);
        @(posedge PCLK); #1;
        chk("abort_psel", a_psel, 0);
        chk("abort_penable", a_penable, 0);
        rsp_cnt = (a_rsp_valid === 1'b1) ? 1 : 0;
        PRESET = 1'b0; stuck[1] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge PCLK); #1;
            if (a_rsp_valid === 1'b1) rsp_cnt++;
        end
        chk("abort_no_rsp", rsp_cnt, 0);

        // Normal command after the abort
        a_prdata = 16'h00_5E;
        do_cmd("rd_s0_after_abort", 1'b0, 1'b0, 10'h0F0, 8'h00, 1'b0, 8'h5E, 3);

        // Three-slave instance: index 3 is a decode error, index 2 is a real slave
        do_cmd("decerr", 1'b1, 1'b0, 10'h3F0, 8'h00, 1'b1, 8'h00, 2);
        chk("decerr_no_psel", psel_ever, 0);
        do_cmd("rd_s2", 1'b1, 1'b0, 10'h2A0, 8'h00, 1'b0, 8'h33, 3);
        chk("rd_s2_setup_psel", psel_c1, 3'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
